// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch unit.
//   fetch_state_e : fetch FSM encoding
//   INST_BYTES    : instruction size in bytes, used as the pc step
//   word_align()  : clears byte-offset bits [1:0] of an address
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_ISSUE    = 2'd0,
        ST_LOOKUP   = 2'd1,
        ST_MISS_REQ = 2'd2,
        ST_FILL     = 2'd3
    } fetch_state_e;

    localparam logic [31:0] INST_BYTES = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_obuf.sv
// fetch_obuf: single-entry output register between fetch and decode.
//   clk, reset     : clock, async active-low reset
//   i_load         : capture i_inst/i_pc (caller only loads when o_can_load)
//   i_flush        : drop the held entry (takes priority over i_load)
//   i_ready        : decode accepts the held entry this cycle
//   o_valid/o_inst/o_pc : held entry, stable while o_valid && !i_ready
//   o_can_load     : entry is empty or leaving this cycle
module fetch_obuf (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic        i_ready,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_can_load
);

    logic        r_valid;
    logic [31:0] r_inst;
    logic [31:0] r_pc;

    assign o_valid    = r_valid;
    assign o_inst     = r_inst;
    assign o_pc       = r_pc;
    assign o_can_load = !r_valid || i_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_inst  <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            // a transfer in this same cycle still completes; only the
            // state of the entry afterwards is forced empty
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_inst  <= i_inst;
            r_pc    <= i_pc;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: sequential instruction fetch with iCache lookup and
// single-outstanding miss refill.
//   clk, reset          : clock, async active-low reset
//   ic_addr             : iCache lookup address (current pc)
//   ic_hit, ic_data     : registered iCache response for last ic_addr
//   fill_en/addr/data   : one-cycle iCache refill write
//   mem_req/addr        : memory read request, held until mem_ack
//   mem_ack, mem_rdata  : memory response pulse + data
//   redirect_valid/pc   : branch/jump redirect
//   inst_valid/ready    : decode handshake
//   inst, inst_pc       : instruction word and its address
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] ic_addr,
    input  logic        ic_hit,
    input  logic [31:0] ic_data,
    output logic        fill_en,
    output logic [31:0] fill_addr,
    output logic [31:0] fill_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);
    import fetch_pkg::*;

    localparam logic [31:0] LP_RESET_PC = word_align(RESET_PC);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_miss_addr;
    logic [31:0]  r_fill_data;
    logic         w_can_load;
    logic         w_load;

    // Redirect wins over a same-cycle hit: the hit word is dropped.
    assign w_load = (r_state == ST_LOOKUP) && ic_hit && w_can_load && !redirect_valid;

    // Request/fill outputs decode straight from state so an async reset
    // drops mem_req immediately without waiting for a clock edge.
    assign ic_addr   = r_pc;
    assign mem_req   = (r_state == ST_MISS_REQ);
    assign mem_addr  = r_miss_addr;
    assign fill_en   = (r_state == ST_FILL);
    assign fill_addr = r_miss_addr;
    assign fill_data = r_fill_data;

    fetch_obuf u_obuf (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_flush    (redirect_valid),
        .i_ready    (inst_ready),
        .i_inst     (ic_data),
        .i_pc       (r_pc),
        .o_valid    (inst_valid),
        .o_inst     (inst),
        .o_pc       (inst_pc),
        .o_can_load (w_can_load)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_ISSUE;
            r_pc        <= LP_RESET_PC;
            r_miss_addr <= '0;
            r_fill_data <= '0;
        end else begin
            case (r_state)
                ST_ISSUE: r_state <= redirect_valid ? ST_ISSUE : ST_LOOKUP;
                ST_LOOKUP: begin
                    if (redirect_valid) begin
                        r_state <= ST_ISSUE;
                    end else if (!ic_hit) begin
                        r_miss_addr <= r_pc;
                        r_state     <= ST_MISS_REQ;
                    end else if (w_can_load) begin
                        r_pc    <= r_pc + INST_BYTES;   // wraps mod 2^32
                        r_state <= ST_ISSUE;
                    end
                end
                // A redirect here only retargets pc; the outstanding
                // request and its fill run to completion.
                ST_MISS_REQ: begin
                    if (mem_ack) begin
                        r_fill_data <= mem_rdata;
                        r_state     <= ST_FILL;
                    end
                end
                ST_FILL: r_state <= ST_ISSUE;
                default: r_state <= ST_ISSUE;
            endcase
            if (redirect_valid) r_pc <= word_align(redirect_pc);
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    localparam logic [31:0] K       = 32'hC0DE_0000;  // model iCache word = addr ^ K
    localparam int          MEM_LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ic_addr;
    logic        ic_hit;
    logic [31:0] ic_data;
    logic        fill_en;
    logic [31:0] fill_addr, fill_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst, inst_pc;

    logic        tb_miss_armed = 1'b0;
    logic [31:0] tb_miss_addr  = '0;
    logic [31:0] tb_mem_word   = '0;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] fill_q[$];

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .ic_addr(ic_addr), .ic_hit(ic_hit), .ic_data(ic_data),
        .fill_en(fill_en), .fill_addr(fill_addr), .fill_data(fill_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
    );

    // iCache model: hits everywhere except one armed address until it is filled.
    logic        m_filled;
    logic [31:0] m_fill_addr, m_fill_word;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ic_hit <= 1'b0; ic_data <= '0;
            m_filled <= 1'b0; m_fill_addr <= '0; m_fill_word <= '0;
        end else begin
            if (m_filled && ic_addr == m_fill_addr) begin
                ic_hit <= 1'b1; ic_data <= m_fill_word;
            end else if (tb_miss_armed && ic_addr == tb_miss_addr) begin
                ic_hit <= 1'b0; ic_data <= 32'hDEAD_BEEF;
            end else begin
                ic_hit <= 1'b1; ic_data <= ic_addr ^ K;
            end
            if (fill_en) begin
                m_filled <= 1'b1; m_fill_addr <= fill_addr; m_fill_word <= fill_data;
            end
        end
    end

    // Memory model: ack MEM_LAT cycles after mem_req rises.
    int m_cnt;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_ack <= 1'b0; mem_rdata <= '0; m_cnt <= 0;
        end else if (mem_ack) begin
            mem_ack <= 1'b0; m_cnt <= 0;
        end else if (mem_req) begin
            if (m_cnt + 1 >= MEM_LAT) begin
                mem_ack <= 1'b1; mem_rdata <= tb_mem_word;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // Reset, then release with an optional redirect in the first ISSUE.
    // Returns just after that first edge (E1); the next negedge is cycle 1.
    task automatic start_at(input logic [31:0] pc, input bit redir, input bit armed,
                            input logic [31:0] maddr, input logic [31:0] mword);
        @(posedge clk); #1;
        reset = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
        tb_miss_armed = armed; tb_miss_addr = maddr; tb_mem_word = mword;
        exp_q.delete(); fill_q.delete();
        @(posedge clk); #1;
        reset = 1'b1; inst_ready = 1'b1; redirect_valid = redir; redirect_pc = pc;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        total++;
        if ({inst_valid, inst, inst_pc} !== 65'd0) begin
            bad++; $display("FAIL reset_obuf: got v=%b inst=%h pc=%h want 0/0/0", inst_valid, inst, inst_pc);
        end
        total++;
        if ({mem_req, mem_addr} !== 33'd0) begin
            bad++; $display("FAIL reset_mem: got req=%b addr=%h want 0/0", mem_req, mem_addr);
        end
        total++;
        if ({fill_en, fill_addr, fill_data} !== 65'd0) begin
            bad++; $display("FAIL reset_fill: got en=%b addr=%h data=%h want 0/0/0", fill_en, fill_addr, fill_data);
        end
        total++;
        if (ic_addr !== 32'h0) begin
            bad++; $display("FAIL reset_pc: got %h want 00000000", ic_addr);
        end
    endtask

    task automatic test_hit_streak();
        logic [63:0] e;
        start_at(32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 6; i++) exp_q.push_back({32'(i * 4), 32'(i * 4) ^ K});
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k == 13) inst_ready = 1'b0;
            if (fill_en) begin
                total++; if (fill_q.size() != 0) e = fill_q.pop_front(); else e = 'x;
                if ({fill_addr, fill_data} !== e) begin bad++; $display("FAIL hit_fill: got %h/%h want %h", fill_addr, fill_data, e); end
            end
            if (inst_valid && inst_ready) begin
                total++; if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 'x;
                if ({inst_pc, inst} !== e) begin bad++; $display("FAIL hit_inst: got pc=%h inst=%h want %h", inst_pc, inst, e); end
            end
            total++;
            if (inst_valid !== (k % 2 == 0)) begin
                bad++; $display("FAIL hit_rate: cycle %0d got valid=%b want %b", k, inst_valid, (k % 2 == 0));
            end
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL hit_drain: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_miss();
        logic [63:0] e;
        int req_first = -1, req_cnt = 0, fill_cyc = -1, inst_cyc = -1;
        start_at(32'h40, 1'b1, 1'b1, 32'h40, 32'h0050_0093);
        fill_q.push_back({32'h40, 32'h0050_0093});
        exp_q.push_back({32'h40, 32'h0050_0093});
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 11) inst_ready = 1'b0;
            if (fill_en) begin
                fill_cyc = k;
                total++; if (fill_q.size() != 0) e = fill_q.pop_front(); else e = 'x;
                if ({fill_addr, fill_data} !== e) begin bad++; $display("FAIL miss_fill: got %h/%h want %h", fill_addr, fill_data, e); end
            end
            if (inst_valid && inst_ready) begin
                inst_cyc = k;
                total++; if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 'x;
                if ({inst_pc, inst} !== e) begin bad++; $display("FAIL miss_inst: got pc=%h inst=%h want %h", inst_pc, inst, e); end
            end
            if (mem_req) begin
                if (req_first < 0) req_first = k;
                req_cnt++;
                total++;
                if (mem_addr !== 32'h40) begin bad++; $display("FAIL miss_addr: got %h want 00000040", mem_addr); end
            end
        end
        total++;
        if (req_cnt != MEM_LAT + 1 || fill_cyc - req_first != MEM_LAT + 1) begin
            bad++; $display("FAIL miss_req_hold: got req_cycles=%0d fill_after=%0d want %0d/%0d", req_cnt, fill_cyc - req_first, MEM_LAT + 1, MEM_LAT + 1);
        end
        total++;
        if (inst_cyc - fill_cyc != 3) begin
            bad++; $display("FAIL miss_penalty: got fill->inst=%0d want 3", inst_cyc - fill_cyc);
        end
        total++;
        if (exp_q.size() != 0 || fill_q.size() != 0) begin
            bad++; $display("FAIL miss_drain: got inst=%0d fill=%0d left want 0/0", exp_q.size(), fill_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] e;
        start_at(32'h20, 1'b1, 1'b0, 32'h0, 32'h0);
        inst_ready = 1'b0;
        exp_q.push_back({32'h20, 32'h20 ^ K});
        exp_q.push_back({32'h24, 32'h24 ^ K});
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 8) inst_ready = 1'b1;
            if (k == 10) inst_ready = 1'b0;
            if (inst_valid && inst_ready) begin
                total++; if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 'x;
                if ({inst_pc, inst} !== e) begin bad++; $display("FAIL bp_inst: got pc=%h inst=%h want %h", inst_pc, inst, e); end
            end
            if (k >= 3 && k <= 7) begin
                total++;
                if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h20, 32'h20 ^ K}) begin
                    bad++; $display("FAIL bp_hold: cycle %0d got v=%b pc=%h inst=%h want 1/00000020/%h", k, inst_valid, inst_pc, inst, 32'h20 ^ K);
                end
            end
            if (k >= 3 && k <= 8) begin
                total++;
                if (ic_addr !== 32'h24) begin bad++; $display("FAIL bp_pc: cycle %0d got %h want 00000024", k, ic_addr); end
            end
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL bp_drain: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_redirect_hit();
        logic [63:0] e;
        start_at(32'h200, 1'b1, 1'b0, 32'h0, 32'h0);
        exp_q.push_back({32'h300, 32'h300 ^ K});
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 2) begin redirect_valid = 1'b1; redirect_pc = 32'h301; end
            if (k == 3) redirect_valid = 1'b0;
            if (k == 6) inst_ready = 1'b0;
            if (inst_valid && inst_ready) begin
                total++; if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 'x;
                if ({inst_pc, inst} !== e) begin bad++; $display("FAIL rdh_inst: got pc=%h inst=%h want %h", inst_pc, inst, e); end
            end
            if (k == 3) begin
                total++;
                if ({inst_valid, ic_addr} !== {1'b0, 32'h300}) begin
                    bad++; $display("FAIL rdh_discard: got v=%b ic_addr=%h want 0/00000300", inst_valid, ic_addr);
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL rdh_drain: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_redirect_miss();
        logic [63:0] e;
        start_at(32'h80, 1'b1, 1'b1, 32'h80, 32'hCAFE_0001);
        fill_q.push_back({32'h80, 32'hCAFE_0001});
        exp_q.push_back({32'h100, 32'h100 ^ K});
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 4) begin redirect_valid = 1'b1; redirect_pc = 32'h103; end
            if (k == 5) redirect_valid = 1'b0;
            if (k == 11) inst_ready = 1'b0;
            if (fill_en) begin
                total++; if (fill_q.size() != 0) e = fill_q.pop_front(); else e = 'x;
                if ({fill_addr, fill_data} !== e) begin bad++; $display("FAIL rdm_fill: got %h/%h want %h", fill_addr, fill_data, e); end
            end
            if (inst_valid && inst_ready) begin
                total++; if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 'x;
                if ({inst_pc, inst} !== e) begin bad++; $display("FAIL rdm_inst: got pc=%h inst=%h want %h", inst_pc, inst, e); end
            end
            if (k == 5 || k == 6) begin
                total++;
                if ({mem_req, mem_addr} !== {1'b1, 32'h80}) begin
                    bad++; $display("FAIL rdm_req: cycle %0d got req=%b addr=%h want 1/00000080", k, mem_req, mem_addr);
                end
            end
            if (k == 8) begin
                total++;
                if (ic_addr !== 32'h100) begin bad++; $display("FAIL rdm_pc: got %h want 00000100", ic_addr); end
            end
        end
        total++;
        if (exp_q.size() != 0 || fill_q.size() != 0) begin
            bad++; $display("FAIL rdm_drain: got inst=%0d fill=%0d left want 0/0", exp_q.size(), fill_q.size());
        end
    endtask

    task automatic test_wrap();
        logic [63:0] e;
        start_at(32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 32'h0);
        exp_q.push_back({32'hFFFF_FFFC, 32'hFFFF_FFFC ^ K});
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 4) inst_ready = 1'b0;
            if (inst_valid && inst_ready) begin
                total++; if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 'x;
                if ({inst_pc, inst} !== e) begin bad++; $display("FAIL wrap_inst: got pc=%h inst=%h want %h", inst_pc, inst, e); end
            end
            if (k == 3) begin
                total++;
                if (ic_addr !== 32'h0) begin bad++; $display("FAIL wrap_pc: got %h want 00000000", ic_addr); end
            end
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL wrap_drain: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_miss();
        start_at(32'h40, 1'b1, 1'b1, 32'h40, 32'h1111_2222);
        repeat (3) @(negedge clk);
        total++;
        if (mem_req !== 1'b1) begin bad++; $display("FAIL rmm_pre: got req=%b want 1", mem_req); end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({mem_req, mem_addr, fill_en} !== 34'd0) begin
            bad++; $display("FAIL rmm_async: got req=%b addr=%h fill=%b want 0/0/0", mem_req, mem_addr, fill_en);
        end
        @(posedge clk); #1;
        inst_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (ic_addr !== 32'h0) begin bad++; $display("FAIL rmm_restart: got ic_addr=%h want 00000000", ic_addr); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++;
            if ({mem_req, fill_en} !== 2'b00) begin
                bad++; $display("FAIL rmm_quiet: cycle %0d got req=%b fill=%b want 0/0", k, mem_req, fill_en);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hit_streak();
        test_miss();
        test_backpressure();
        test_redirect_hit();
        test_redirect_miss();
        test_wrap();
        test_reset_mid_miss();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address after reset, with bits [1:0] ignored.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low (asserted at 0).
- ic_addr  out  32  lookup address to iCache.
- ic_hit  in  1  iCache hit, registered, valid one cycle after ic_addr.
- ic_data  in  32  iCache word, meaningful only when ic_hit=1.
- fill_en  out  1  one-cycle iCache write strobe.
- fill_addr  out  32  word address to fill.
- fill_data  out  32  word to fill.
- mem_req  out  1  memory read request.
- mem_addr  out  32  memory read address.
- mem_ack  in  1  one-cycle pulse; mem_rdata valid with it.
- mem_rdata  in  32  memory read data.
- redirect_valid  in  1  branch/jump redirect.
- redirect_pc  in  32  redirect target.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts.
- inst  out  32  instruction word.
- inst_pc  out  32  address of inst.

Function
REQ-003 SHALL hold pc[1:0]=0 at all times; incoming redirect_pc[1:0] SHALL be discarded.
REQ-004 SHALL implement FSM states ISSUE, LOOKUP, MISS_REQ, FILL.
REQ-005 ISSUE: drive ic_addr=pc; next state LOOKUP unconditionally.
REQ-006 LOOKUP: ic_addr=pc held. On ic_hit=1 with the output buffer empty or accepted this cycle, load inst=ic_data and inst_pc=pc, set pc=pc+4, and go to ISSUE.
REQ-007 LOOKUP, ic_hit=1, output buffer full and not accepted: stay in LOOKUP, re-evaluating each cycle.
REQ-008 LOOKUP, ic_hit=0: capture miss_addr=pc and go to MISS_REQ; ic_data SHALL never be sampled in this case.
REQ-009 MISS_REQ: mem_req=1 and mem_addr=miss_addr, both held stable until mem_ack. On mem_ack, capture mem_rdata and go to FILL.
REQ-010 FILL: fill_en=1 for exactly one cycle with fill_addr=miss_addr and fill_data=captured word; then go to ISSUE, which re-looks up pc.
REQ-011 Hit-path throughput SHALL be one instruction per 2 cycles.
REQ-012 Miss penalty from LOOKUP SHALL be (cycles to mem_ack) + 1 FILL + 2 (ISSUE and LOOKUP).
REQ-013 Output handshake: transfer occurs when inst_valid && inst_ready. inst and inst_pc SHALL be stable while inst_valid && !inst_ready. inst_valid SHALL clear on transfer unless reloaded in the same cycle.
REQ-014 Redirect in ISSUE or LOOKUP:
- set pc=redirect_pc;
- flush the output buffer (inst_valid=0 next cycle);
- go to ISSUE;
- redirect wins over a simultaneous hit, and the hit data is discarded.
REQ-015 Redirect in MISS_REQ or FILL:
- set pc and flush as in REQ-014;
- state and miss_addr are unchanged;
- the outstanding request completes and its fill is still written;
- the following ISSUE uses the new pc.
REQ-016 Redirect coinciding with a decode transfer: the transfer counts as completed, then the buffer is flushed.
REQ-017 pc+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC becomes 32'h0000_0000.
REQ-018 mem_req SHALL never deassert before mem_ack, and SHALL never be asserted outside MISS_REQ.

Reset
REQ-019 While reset=0, the block SHALL hold these values:
- pc=RESET_PC&~3, state=ISSUE;
- inst_valid=0, inst=0, inst_pc=0;
- mem_req=0, mem_addr=0;
- fill_en=0, fill_addr=0, fill_data=0;
- miss_addr=0.
REQ-020 Reset asserted mid-miss SHALL abandon the request immediately; mem_req=0 asynchronously.
REQ-021 The first ISSUE SHALL occur in the first clk edge after reset deasserts.

Structure
REQ-022 Shared package fetch_pkg SHALL hold the FSM state enum and the constant INST_BYTES=4.
REQ-023 One sub-module, fetch_obuf, SHALL implement the single-entry output register with valid/ready and flush.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Hit streak: RESET_PC=0, model hits everywhere, inst_ready=1 -> inst_pc 0,4,8,... with inst_valid every 2nd cycle.
- Miss: ic_hit=0 at 0x40, mem_ack 3 cycles after mem_req, rdata 0x00500093 -> one fill_en at 0x40/0x00500093, then inst=0x00500093 with inst_pc=0x40.
- Backpressure: inst_ready=0 for 5 cycles with a hit pending -> inst/inst_pc stable, stays in LOOKUP, pc not advanced.
- Redirect during miss: redirect_pc=0x103 while in MISS_REQ for 0x80 -> fill to 0x80 still written, next ic_addr=0x100, no stale inst delivered.
- Wrap: redirect to 0xFFFFFFFC, hit -> inst_pc=0xFFFFFFFC, next ic_addr=0x0.
- Reset mid-miss: reset=0 while mem_req=1 -> mem_req=0 immediately; after release, ic_addr=RESET_PC.
